pp_ctrl: RTL
============

# pp_ctrl

Control unit for the ping-pong game. It drives the load/clear side of the 8-bit ball-position datapath register and reads the register's output back. It sequences serve, rally, point scoring and game-over from player buttons and a game-step tick. It owns both player scores and is the only writer of the ball register's `a`/`ld`/`clr` inputs.

## Interface
Parameters:
- WIN_SCORE, 7, score (1..15) at which a player wins the game.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- clr  in  1  reset, asynchronous, active-high.
- tick  in  1  one-cycle game-step strobe; at least 2 cycles between strobes.
- btn_l  in  1  left player button, already synchronised; level.
- btn_r  in  1  right player button, already synchronised; level.
- ball_q  in  8  ball register output, one-hot; bit 7 = left end, bit 0 = right end.
- ball_d  out  8  next ball value presented to the register's `a` input.
- ball_ld  out  1  one-cycle load strobe to the register's `ld` input.
- ball_clr  out  1  one-cycle clear strobe to the register's `clr` input.
- score_l  out  4  left player score.
- score_r  out  4  right player score.
- game_over  out  1  high while in the OVER state.
- winner  out  1  0 = left, 1 = right; valid while game_over is high.

## Operation
- Button events are internal rising-edge detects: `ev_l = btn_l & ~btn_l_d`. The edge-detect flops reset to 0.
- States and transitions:
  - SERVE_L: entered from reset. On ev_l: ball_d=8'h80, ball_ld=1, go to MOVE_R. Any other event is ignored.
  - SERVE_R: on ev_r: ball_d=8'h01, ball_ld=1, go to MOVE_L. Any other event is ignored.
  - MOVE_R:
    - ev_r while ball_q==8'h01 is a hit: ball_d=8'h02, ball_ld=1, go to MOVE_L.
    - Else on tick with ball_q!=8'h01: ball_d=ball_q>>1, ball_ld=1.
    - Else on tick with ball_q==8'h01 (miss): go to PT_L.
  - MOVE_L mirrors MOVE_R: hit window is ball_q==8'h80, hit loads 8'h40, advance is ball_q<<1, miss goes to PT_R.
  - PT_L and PT_R each last one cycle:
    - Increment the winner's score and pulse ball_clr=1.
    - If the new score == WIN_SCORE, go to OVER. Otherwise the point winner serves: PT_L goes to SERVE_L, PT_R goes to SERVE_R.
  - OVER: game_over=1 and winner is held. On ev_l or ev_r: scores clear to 0, ball_clr=1, go to SERVE_L.
- Priority: a hit beats a tick in the same cycle. ev_l in MOVE_R and ev_r in MOVE_L are ignored, except as described under Configuration.
- ball_ld and ball_clr are never high in the same cycle. Both are low in all other cycles.
- Scores saturate at WIN_SCORE and never wrap.

## Timing
- Reset values:
  - state SERVE_L.
  - ball_d, ball_ld, ball_clr, score_l, score_r, game_over and winner all 0.
- ball_ld and ball_clr are registered outputs that go high in the cycle after the deciding event. The ball register updates one edge later, so ball_q reflects the load 2 cycles after the event.
- Events in the 2 cycles after a ball_ld are evaluated against the new state, with ball_q taken as not yet valid.
  - Hit and end tests therefore use an internal position shadow that updates with ball_ld, not ball_q.
  - ball_q is used only for advance arithmetic, once it is valid.
- Reset mid-rally forces SERVE_L at once. Scores clear and no ball_clr pulse is issued; the register is cleared by its own reset path.

## Configuration
- PP_EARLY_FAULT_EN defined: a button event from the receiving player while the ball is outside that player's hit window is a fault.
  - In MOVE_R, ev_r with shadow!=8'h01 goes to PT_L.
  - In MOVE_L, ev_l with shadow!=8'h80 goes to PT_R.
- Not defined: early presses are ignored.

## Test plan
- Reset, then ev_l → ball_ld pulse with ball_d=8'h80 next cycle. After 7 ticks the shadow is 8'h01 and no ball_ld has carried a value other than the shift sequence.
- Ball at 8'h01, ev_r and tick in the same cycle → hit: ball_d=8'h02 and state MOVE_L. score_l is unchanged.
- Ball at 8'h01, tick with no ev_r → score_l=1, one ball_clr pulse, then SERVE_L. ev_r is ignored until ev_l serves.
- Run 7 misses by the right player with WIN_SCORE=7 → score_l=7, game_over=1, winner=0. Then ev_r → scores 0 and SERVE_L.
- With PP_EARLY_FAULT_EN, ball at 8'h20 moving right, ev_r → score_l increments. Without the macro, same stimulus → no change.
- Assert clr mid-rally at ball 8'h08 → all outputs 0 immediately, asynchronously; the first ev_l after release serves from 8'h80.

Source files
------------

// File: rtl/pp_ctrl.sv
// rtl/pp_ctrl.sv - ping-pong game control unit driving the ball-position register
//
// Ports:
//   clk        system clock, all state changes on posedge
//   clr        asynchronous active-high reset
//   tick       one-cycle game-step strobe
//   btn_l      left player button (synchronised level)
//   btn_r      right player button (synchronised level)
//   ball_q     ball register output, one-hot, bit 7 = left end
//   ball_d     next ball value for the register's a input
//   ball_ld    one-cycle load strobe for the register
//   ball_clr   one-cycle clear strobe for the register
//   score_l    left player score
//   score_r    right player score
//   game_over  high while the game is over
//   winner     0 = left, 1 = right; valid while game_over is high
//
// Optional feature macro: PP_EARLY_FAULT_EN
//   defined     a press by the receiving player outside the hit window loses the point
//   not defined early presses are ignored

module pp_ctrl #(
    parameter int WIN_SCORE = 7
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic [7:0] ball_q,
    output logic [7:0] ball_d,
    output logic       ball_ld,
    output logic       ball_clr,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [2:0] {
        SERVE_L,
        SERVE_R,
        MOVE_R,
        MOVE_L,
        PT_L,
        PT_R,
        OVER
    } state_t;

    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    state_t     state;
    logic       btn_l_d;
    logic       btn_r_d;
    logic       ev_l;
    logic       ev_r;
    // Shadow of the ball position, updated together with ball_ld so that
    // hit/end decisions never depend on the register's delayed output.
    logic [7:0] pos;
    // Cycles remaining until ball_q reflects the most recent load.
    logic [1:0] q_age;
    logic [7:0] src;
    logic [3:0] nxt_l;
    logic [3:0] nxt_r;

    assign ev_l  = btn_l & ~btn_l_d;
    assign ev_r  = btn_r & ~btn_r_d;
    // Advance arithmetic reads the register once its output is settled,
    // falling back to the shadow while a load is still in flight.
    assign src   = (q_age == 2'd0) ? ball_q : pos;
    assign nxt_l = (score_l < WIN) ? score_l + 4'd1 : WIN;
    assign nxt_r = (score_r < WIN) ? score_r + 4'd1 : WIN;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= SERVE_L;
            btn_l_d   <= 1'b0;
            btn_r_d   <= 1'b0;
            pos       <= 8'h00;
            q_age     <= 2'd0;
            ball_d    <= 8'h00;
            ball_ld   <= 1'b0;
            ball_clr  <= 1'b0;
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            game_over <= 1'b0;
            winner    <= 1'b0;
        end else begin
            btn_l_d  <= btn_l;
            btn_r_d  <= btn_r;
            ball_ld  <= 1'b0;
            ball_clr <= 1'b0;
            if (q_age != 2'd0) begin
                q_age <= q_age - 2'd1;
            end

            case (state)
                SERVE_L: begin
                    if (ev_l) begin
                        ball_d  <= 8'h80;
                        pos     <= 8'h80;
                        ball_ld <= 1'b1;
                        q_age   <= 2'd2;
                        state   <= MOVE_R;
                    end
                end

                SERVE_R: begin
                    if (ev_r) begin
                        ball_d  <= 8'h01;
                        pos     <= 8'h01;
                        ball_ld <= 1'b1;
                        q_age   <= 2'd2;
                        state   <= MOVE_L;
                    end
                end

                MOVE_R: begin
                    // A hit outranks a tick arriving in the same cycle.
                    if (ev_r && pos == 8'h01) begin
                        ball_d  <= 8'h02;
                        pos     <= 8'h02;
                        ball_ld <= 1'b1;
                        q_age   <= 2'd2;
                        state   <= MOVE_L;
`ifdef PP_EARLY_FAULT_EN
                    end else if (ev_r) begin
                        state <= PT_L;
`endif
                    end else if (tick) begin
                        if (pos == 8'h01) begin
                            state <= PT_L;
                        end else begin
                            ball_d  <= src >> 1;
                            pos     <= src >> 1;
                            ball_ld <= 1'b1;
                            q_age   <= 2'd2;
                        end
                    end
                end

                MOVE_L: begin
                    if (ev_l && pos == 8'h80) begin
                        ball_d  <= 8'h40;
                        pos     <= 8'h40;
                        ball_ld <= 1'b1;
                        q_age   <= 2'd2;
                        state   <= MOVE_R;
`ifdef PP_EARLY_FAULT_EN
                    end else if (ev_l) begin
                        state <= PT_R;
`endif
                    end else if (tick) begin
                        if (pos == 8'h80) begin
                            state <= PT_R;
                        end else begin
                            ball_d  <= src << 1;
                            pos     <= src << 1;
                            ball_ld <= 1'b1;
                            q_age   <= 2'd2;
                        end
                    end
                end

                PT_L: begin
                    score_l  <= nxt_l;
                    ball_clr <= 1'b1;
                    if (nxt_l == WIN) begin
                        state     <= OVER;
                        game_over <= 1'b1;
                        winner    <= 1'b0;
                    end else begin
                        state <= SERVE_L;
                    end
                end

                PT_R: begin
                    score_r  <= nxt_r;
                    ball_clr <= 1'b1;
                    if (nxt_r == WIN) begin
                        state     <= OVER;
                        game_over <= 1'b1;
                        winner    <= 1'b1;
                    end else begin
                        state <= SERVE_R;
                    end
                end

                OVER: begin
                    if (ev_l || ev_r) begin
                        score_l   <= 4'd0;
                        score_r   <= 4'd0;
                        ball_clr  <= 1'b1;
                        game_over <= 1'b0;
                        state     <= SERVE_L;
                    end
                end

                default: begin
                    state <= SERVE_L;
                end
            endcase
        end
    end

endmodule
